// File: rtl/seq_feeder.sv
// seq_feeder: drives the four-in-a-row sequence detector from a parallel
// pattern word. A job resets the detector, shifts the pattern into it LSB
// first (DIV setup cycles, one strobe cycle and one hold cycle per bit),
// samples the detector match flag after each bit and reports a saturating
// match count with busy/done handshaking.
//
// Optional feature macro: SEQ_FEEDER_MATCH_CNT_EN
//   defined   -> match_cnt counts bits after which det_match was 1
//   undefined -> match_cnt is constant 0 and det_match is ignored

module seq_feeder #(
    parameter int PAT_W = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       len,
    input  logic             det_match,
    output logic             det_bit,
    output logic             det_stb,
    output logic             det_rst_n,
    output logic             busy,
    output logic             done,
    output logic [3:0]       match_cnt
);

    // Bit index wide enough for PAT_W positions; setup counter for DIV cycles
    // (DIV is at least 2, so DIV_W is at least 1)
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_nxt;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] last_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;

    logic             det_bit_nxt;
    logic             det_stb_nxt;
    logic             det_rst_n_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [31:0]      len_ext;
    logic [31:0]      len_clamped;
    logic [IDX_W-1:0] last_from_len;
    logic             accept;

    // Lengths longer than the pattern are clamped; the job stores the index
    // of its last bit rather than the length itself
    assign len_ext       = {28'd0, len};
    assign len_clamped   = (len_ext > 32'(PAT_W)) ? 32'(PAT_W) : len_ext;
    assign last_from_len = IDX_W'(len_clamped - 32'd1);

    // A job starts only from IDLE, with a nonzero length and no abort
    assign accept = (state == IDLE) && start && !abort && (len != 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; strobe and detector reset default
    // to their idle levels so they pulse only where explicitly requested
    always_comb begin
        state_nxt     = state;
        pat_nxt       = pat_q;
        last_nxt      = last_idx;
        idx_nxt       = bit_idx;
        div_nxt       = div_cnt;
        det_bit_nxt   = det_bit;
        det_stb_nxt   = 1'b0;
        det_rst_n_nxt = 1'b1;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = SETUP;
                    pat_nxt       = pattern;
                    last_nxt      = last_from_len;
                    idx_nxt       = '0;
                    div_nxt       = '0;
                    det_bit_nxt   = pattern[0];
                    busy_nxt      = 1'b1;
                    det_rst_n_nxt = 1'b0;
                end
            end

            SETUP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (div_cnt == DIV_LAST) begin
                    state_nxt   = PULSE;
                    det_stb_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            PULSE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (bit_idx == last_idx) begin
                    state_nxt = FINISH;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt   = SETUP;
                    idx_nxt     = bit_idx + 1'b1;
                    div_nxt     = '0;
                    det_bit_nxt = pat_q[idx_nxt];
                end
            end

            FINISH: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Job context and registered detector/handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q     <= '0;
            last_idx  <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            det_bit   <= 1'b0;
            det_stb   <= 1'b0;
            det_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pat_q     <= pat_nxt;
            last_idx  <= last_nxt;
            bit_idx   <= idx_nxt;
            div_cnt   <= div_nxt;
            det_bit   <= det_bit_nxt;
            det_stb   <= det_stb_nxt;
            det_rst_n <= det_rst_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef SEQ_FEEDER_MATCH_CNT_EN
    // Count bits after which the detector reported four equal, saturating at
    // 15; cleared on accept and frozen by an abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= 4'd0;
        end else if (accept) begin
            match_cnt <= 4'd0;
        end else if ((state == HOLD) && !abort && det_match && (match_cnt != 4'd15)) begin
            match_cnt <= match_cnt + 4'd1;
        end
    end
`else
    logic unused_det_match;
    assign unused_det_match = det_match;
    assign match_cnt        = 4'd0;
`endif

endmodule

// File: tb/tb_seq_feeder.sv
// Self-checking bench for seq_feeder with an ideal four-in-a-row detector.
// Jobs from a vector table push their expectations onto a scoreboard queue
// when started and are compared once the job has been observed.

module tb_seq_feeder;

    localparam int PAT_W   = 8;
    localparam int DIV     = 4;
    localparam int BIT_CYC = DIV + 2;
    localparam int OBS_CYC = 8 * BIT_CYC + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       det_match;
    logic       det_bit;
    logic       det_stb;
    logic       det_rst_n;
    logic       busy;
    logic       done;
    logic [3:0] match_cnt;

    seq_feeder #(
        .PAT_W(PAT_W),
        .DIV  (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .len      (len),
        .det_match(det_match),
        .det_bit  (det_bit),
        .det_stb  (det_stb),
        .det_rst_n(det_rst_n),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Ideal detector: shift on strobe, flag when the last four bits agree
    logic [3:0] hist   = 4'd0;
    int         dcount = 0;

    always @(posedge det_stb or negedge det_rst_n) begin
        if (!det_rst_n) begin
            hist   <= 4'd0;
            dcount <= 0;
        end else begin
            hist <= {hist[2:0], det_bit};
            if (dcount < 4) dcount <= dcount + 1;
        end
    end

    assign det_match = (dcount >= 4) && ((hist == 4'hF) || (hist == 4'h0));

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] len;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    typedef struct {
        int         busy;
        int         done_cycle;
        int         done_cnt;
        int         stb;
        logic [7:0] bits;
        int         rst_low;
        int         match;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks    = 0;
    int         n_fail      = 0;
    int         model_match = 0;

    int         obs_busy;
    int         obs_done_cycle;
    int         obs_done_cnt;
    int         obs_stb;
    logic [7:0] obs_bits;
    int         obs_rst_low;
    int         obs_match;

    // Reference count: a match after bit i when the run of equal bits ending there is >= 4
    function automatic int refMatch(input logic [7:0] p, input int n);
        int   run;
        int   cnt;
        logic prev;
        run  = 0;
        cnt  = 0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ((i > 0) && (p[i] == prev)) run++;
            else run = 1;
            prev = p[i];
            if ((run >= 4) && (cnt < 15)) cnt++;
        end
`ifdef SEQ_FEEDER_MATCH_CNT_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [3:0] l,
                                 input int exp_busy, input int exp_done);
        exp_t       e;
        int         n;
        logic [8:0] m;
        n = (l > 4'd8) ? 8 : int'(l);
        m = (9'd1 << n) - 9'd1;
        e.busy       = exp_busy;
        e.done_cycle = exp_done;
        e.done_cnt   = (n > 0) ? 1 : 0;
        e.stb        = n;
        e.bits       = p & m[7:0];
        e.rst_low    = (n > 0) ? 1 : 0;
        if (n > 0) model_match = refMatch(p, n);
        e.match      = model_match;
        sb_q.push_back(e);
        pattern = p;
        len     = l;
        start   = 1'b1;
    endtask

    task automatic observe(input int ncyc);
        obs_busy       = 0;
        obs_done_cycle = 0;
        obs_done_cnt   = 0;
        obs_stb        = 0;
        obs_bits       = 8'd0;
        obs_rst_low    = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) obs_busy++;
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cycle == 0) obs_done_cycle = k;
            end
            if (det_stb) begin
                if (obs_stb < 8) obs_bits[obs_stb] = det_bit;
                obs_stb++;
            end
            if (!det_rst_n) obs_rst_low++;
        end
        obs_match = int'(match_cnt);
    endtask

    task automatic compareJob(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, " busy cycles"}, obs_busy, e.busy);
            checkOutput({tag, " done cycle"}, obs_done_cycle, e.done_cycle);
            checkOutput({tag, " done pulses"}, obs_done_cnt, e.done_cnt);
            checkOutput({tag, " strobes"}, obs_stb, e.stb);
            checkOutput({tag, " bits"}, int'(obs_bits), int'(e.bits));
            checkOutput({tag, " det_rst_n low"}, obs_rst_low, e.rst_low);
            checkOutput({tag, " match_cnt"}, obs_match, e.match);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " det_bit"}, det_bit, 0);
        checkOutput({tag, " det_stb"}, det_stb, 0);
        checkOutput({tag, " det_rst_n"}, det_rst_n, 1);
        checkOutput({tag, " match_cnt"}, int'(match_cnt), 0);
    endtask

    // Abort during the strobe of a 1-based bit number, then restart at once
    task automatic abortTest(input int bitno);
        int exp_m;
        exp_m   = refMatch(8'hFF, bitno - 1);
        pattern = 8'hFF;
        len     = 4'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ((bitno - 1) * BIT_CYC + DIV) @(negedge clk);
        checkOutput($sformatf("abort bit%0d strobe seen", bitno), det_stb, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput($sformatf("abort bit%0d busy", bitno), busy, 0);
        checkOutput($sformatf("abort bit%0d done", bitno), done, 0);
        checkOutput($sformatf("abort bit%0d det_stb", bitno), det_stb, 0);
        checkOutput($sformatf("abort bit%0d det_rst_n", bitno), det_rst_n, 1);
        checkOutput($sformatf("abort bit%0d match_cnt", bitno), int'(match_cnt), exp_m);
        model_match = exp_m;
        applyStimulus(8'h03, 4'd2, 2 * BIT_CYC, 2 * BIT_CYC + 1);
        observe(OBS_CYC);
        compareJob($sformatf("restart after abort bit%0d", bitno));
    endtask

    initial begin
        vec_t vecs[7];
        int   busy_total;
        int   done_total;
        int   done_first;
        int   done_second;
        int   busy14;
        int   busy15;
        int   overlap;
        int   cnt_nonzero;

        vecs[0] = '{8'h0F, 4'd8,  48, 49};
        vecs[1] = '{8'hFF, 4'd15, 48, 49};
        vecs[2] = '{8'hA5, 4'd0,  0,  0};
        vecs[3] = '{8'hA5, 4'd3,  18, 19};
        vecs[4] = '{8'hF0, 4'd8,  48, 49};
        vecs[5] = '{8'hE7, 4'd9,  48, 49};
        vecs[6] = '{8'h01, 4'd1,  6,  7};

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'd0;
        len     = 4'd0;
        #2 rst = 1'b0;
        #1 checkResetOutputs("power-on reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].pattern, vecs[i].len, vecs[i].exp_busy, vecs[i].exp_done);
            observe(OBS_CYC);
            compareJob($sformatf("vec%0d", i));
        end

        // Reset in the middle of a job, during the strobe of bit 2
        pattern = 8'hFF;
        len     = 4'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (BIT_CYC + DIV) @(negedge clk);
        checkOutput("midjob strobe before reset", det_stb, 1);
        rst = 1'b0;
        #1 checkResetOutputs("midjob reset");
        @(negedge clk);
        rst = 1'b1;
        model_match = 0;
        @(negedge clk);
        applyStimulus(8'h3C, 4'd8, 48, 49);
        observe(OBS_CYC);
        compareJob("after midjob reset");

        abortTest(3);
        abortTest(6);

        // start held high across a whole two-bit job
        busy_total  = 0;
        done_total  = 0;
        done_first  = 0;
        done_second = 0;
        busy14      = -1;
        busy15      = -1;
        overlap     = 0;
        cnt_nonzero = 0;
        pattern     = 8'h03;
        len         = 4'd2;
        start       = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_total++;
            if (done) begin
                done_total++;
                if (done_first == 0) done_first = k;
                else if (done_second == 0) done_second = k;
            end
            if (busy && done) overlap++;
            if (match_cnt != 4'd0) cnt_nonzero++;
            if (k == 14) busy14 = busy;
            if (k == 15) begin
                busy15 = busy;
                start  = 1'b0;
            end
        end
        checkOutput("held start busy cycles", busy_total, 4 * BIT_CYC);
        checkOutput("held start done pulses", done_total, 2);
        checkOutput("held start first done", done_first, 2 * BIT_CYC + 1);
        checkOutput("held start second done", done_second, 4 * BIT_CYC + 3);
        checkOutput("held start idle gap", busy14, 0);
        checkOutput("held start second accept", busy15, 1);
        checkOutput("held start busy/done overlap", overlap, 0);
        checkOutput("held start match_cnt nonzero", cnt_nonzero, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
